// File: rtl/ram_io_responder_if.sv
// Byte-wide memory bus between the memory controller (master) and the RAM/IO responder (slave).
// Also carries the TX drain port and the sticky status flags.
interface ram_io_responder_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        io_tx_valid;
  logic [7:0]  io_tx_data;
  logic        io_tx_ready;
  logic        prog_done;
  logic        tx_overflow;

  modport master (
    output mem_a, mem_dout, mem_wr, io_tx_ready,
    input  mem_din, io_buffer_full, io_tx_valid, io_tx_data, prog_done, tx_overflow
  );

  modport slave (
    input  mem_a, mem_dout, mem_wr, io_tx_ready,
    output mem_din, io_buffer_full, io_tx_valid, io_tx_data, prog_done, tx_overflow
  );
endinterface

// File: rtl/ram_io_responder.sv
// Synchronous byte RAM plus IO window (TX FIFO, status, program-done) on the controller bus.
// RAM starts uninitialised; INIT_FILE is retained as a parameter only.
module ram_io_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH = 8,
   parameter     INIT_FILE  = "test.data"
) (
   input logic               clk_in,
   input logic               rst_n_in,
   input logic               rdy_in,
   ram_io_responder_if.slave bus
);

   localparam int PtrW = $clog2(FIFO_DEPTH);
   localparam int CntW = PtrW + 1;

   typedef enum logic [1:0] {SrcZero, SrcRam, SrcStat} rdSrc_t;

   logic [7:0] ram [0:(2**ADDR_WIDTH)-1];
   logic [7:0] fifoMem [0:FIFO_DEPTH-1];

   logic [7:0]      ramRd_q;
   rdSrc_t          rdSrc_q, rdSrc_d;
   logic [1:0]      stat_q, stat_d;
   logic [PtrW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            bufFull_q, bufFull_d;
   logic            ovf_q, ovf_d;
   logic            prog_q, prog_d;

   logic                  ioSel, txAddr, statAddr, fifoFull, push, pop, ramWe;
   logic [ADDR_WIDTH-1:0] ramIdx;
   logic                  unusedBits;

   localparam int unusedInitBits = $bits(INIT_FILE);

   assign unusedBits = ^bus.mem_a[31:18];

   assign ioSel    = (bus.mem_a[17:16] == 2'b11);
   assign txAddr   = ioSel && (bus.mem_a[15:0] == 16'h0000);
   assign statAddr = ioSel && (bus.mem_a[15:0] == 16'h0004);
   assign ramIdx   = bus.mem_a[ADDR_WIDTH-1:0];
   assign fifoFull = (count_q == CntW'(FIFO_DEPTH));
   assign push     = rdy_in && bus.mem_wr && txAddr && !fifoFull;
   assign pop      = rdy_in && bus.io_tx_ready && (count_q != '0);
   // Writes are blocked while reset is held so an interrupted access never lands in RAM.
   assign ramWe    = rdy_in && rst_n_in && bus.mem_wr && !ioSel;

   // RAM port: registered read of the old byte, write of the new byte on the same edge.
   always_ff @(posedge clk_in) begin
      if (rdy_in) begin
         ramRd_q <= ram[ramIdx];
         if (ramWe) ram[ramIdx] <= bus.mem_dout;
      end
   end

   // FIFO storage: accepted pushes land at the write pointer.
   always_ff @(posedge clk_in) begin
      if (push) fifoMem[wrPtr_q] <= bus.mem_dout;
   end

   // Next-state logic for read source, pointers, count and sticky flags; all hold while rdy_in is low.
   always_comb begin
      rdSrc_d   = rdSrc_q;
      stat_d    = stat_q;
      rdPtr_d   = rdPtr_q;
      wrPtr_d   = wrPtr_q;
      count_d   = count_q;
      bufFull_d = bufFull_q;
      ovf_d     = ovf_q;
      prog_d    = prog_q;
      if (rdy_in) begin
         rdSrc_d = ioSel ? (statAddr ? SrcStat : SrcZero) : SrcRam;
         stat_d  = {ovf_q, bufFull_q};
         if (push) wrPtr_d = wrPtr_q + PtrW'(1);
         if (pop)  rdPtr_d = rdPtr_q + PtrW'(1);
         count_d   = count_q + CntW'(push) - CntW'(pop);
         // Two-entry margin absorbs the store accepted while the controller samples the flag.
         bufFull_d = (count_d >= CntW'(FIFO_DEPTH - 2));
         if (bus.mem_wr && txAddr && fifoFull) ovf_d = 1'b1;
         if (bus.mem_wr && statAddr) prog_d = 1'b1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         rdSrc_q   <= SrcZero;
         stat_q    <= 2'b00;
         rdPtr_q   <= '0;
         wrPtr_q   <= '0;
         count_q   <= '0;
         bufFull_q <= 1'b0;
         ovf_q     <= 1'b0;
         prog_q    <= 1'b0;
      end else begin
         rdSrc_q   <= rdSrc_d;
         stat_q    <= stat_d;
         rdPtr_q   <= rdPtr_d;
         wrPtr_q   <= wrPtr_d;
         count_q   <= count_d;
         bufFull_q <= bufFull_d;
         ovf_q     <= ovf_d;
         prog_q    <= prog_d;
      end
   end

   // Read data mux selected by the registered source of the previous access.
   always_comb begin
      bus.mem_din = 8'h00;
      case (rdSrc_q)
         SrcRam:  bus.mem_din = ramRd_q;
         SrcStat: bus.mem_din = {6'b000000, stat_q};
         default: bus.mem_din = 8'h00;
      endcase
   end

   assign bus.io_buffer_full = bufFull_q;
   assign bus.io_tx_valid    = (count_q != '0);
   assign bus.io_tx_data     = (count_q != '0) ? fifoMem[rdPtr_q] : 8'h00;
   assign bus.prog_done      = prog_q;
   assign bus.tx_overflow    = ovf_q;

endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: vector table, directed corner cases and a
// randomized run against a queue/array reference model.
module tb_ram_io_responder;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    bit          wr;
    bit          txr;
    bit          chkDin;
    logic [7:0]  expDin;
    bit          expValid;
    logic [7:0]  expData;
    bit          expFull;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;

  ram_io_responder_if bus();

  ram_io_responder #(
    .ADDR_WIDTH(17),
    .FIFO_DEPTH(DEPTH),
    .INIT_FILE ("test.data")
  ) dut (
    .clk_in  (clk),
    .rst_n_in(rst_n),
    .rdy_in  (rdy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] ramModel [int];
  logic [7:0] fifoQ [$];
  bit         mOvf = 1'b0;
  bit         mProg = 1'b0;
  logic [7:0] mDin = 8'h00;
  bit         mDinKnown = 1'b1;

  vec_t vecs [14];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour of one clock edge, derived from the bus rules directly.
  task automatic modelStep(input logic [31:0] a, input logic [7:0] d, input bit wr,
                           input bit txr, input bit en);
    bit io = (a[17:16] == 2'b11);
    int idx = int'(a[16:0]);
    int sz = fifoQ.size();
    bit fullNow = (sz >= DEPTH - 2);
    if (!en) return;
    if (io) begin
      mDinKnown = 1'b1;
      mDin = (a[17:0] == 18'h30004) ? {6'b000000, mOvf, fullNow} : 8'h00;
    end else if (ramModel.exists(idx)) begin
      mDinKnown = 1'b1;
      mDin = ramModel[idx];
    end else begin
      mDinKnown = 1'b0;
    end
    if (sz != 0 && txr) void'(fifoQ.pop_front());
    if (io && wr && a[17:0] == 18'h30000) begin
      if (sz == DEPTH) mOvf = 1'b1;
      else fifoQ.push_back(d);
    end
    if (io && wr && a[17:0] == 18'h30004) mProg = 1'b1;
    if (!io && wr) ramModel[idx] = d;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [7:0] d, input bit wr,
                               input bit txr, input bit en);
    bus.mem_a = a;
    bus.mem_dout = d;
    bus.mem_wr = wr;
    bus.io_tx_ready = txr;
    rdy = en;
    modelStep(a, d, wr, txr, en);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    if (mDinKnown) checkVal({tag, ".din"}, {24'h0, bus.mem_din}, {24'h0, mDin});
    checkVal({tag, ".full"}, {31'h0, bus.io_buffer_full}, {31'h0, fifoQ.size() >= DEPTH - 2});
    checkVal({tag, ".valid"}, {31'h0, bus.io_tx_valid}, {31'h0, fifoQ.size() != 0});
    checkVal({tag, ".data"}, {24'h0, bus.io_tx_data},
             {24'h0, (fifoQ.size() != 0) ? fifoQ[0] : 8'h00});
    checkVal({tag, ".prog"}, {31'h0, bus.prog_done}, {31'h0, mProg});
    checkVal({tag, ".ovf"}, {31'h0, bus.tx_overflow}, {31'h0, mOvf});
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, ".din"}, {24'h0, bus.mem_din}, 32'h0);
    checkVal({tag, ".full"}, {31'h0, bus.io_buffer_full}, 32'h0);
    checkVal({tag, ".valid"}, {31'h0, bus.io_tx_valid}, 32'h0);
    checkVal({tag, ".data"}, {24'h0, bus.io_tx_data}, 32'h0);
    checkVal({tag, ".prog"}, {31'h0, bus.prog_done}, 32'h0);
    checkVal({tag, ".ovf"}, {31'h0, bus.tx_overflow}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{32'h00100, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{32'h00101, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{32'h00102, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{32'h00103, 8'h44, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{32'h00100, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{32'h00101, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0};
    vecs[6]  = '{32'h00102, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{32'h00103, 8'h00, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 8'h00, 1'b0};
    vecs[8]  = '{32'h00200, 8'hAA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{32'h00200, 8'hBB, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{32'h00200, 8'h00, 1'b0, 1'b0, 1'b1, 8'hBB, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{32'h30000, 8'h48, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h48, 1'b0};
    vecs[12] = '{32'h30000, 8'h69, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 8'h69, 1'b0};
    vecs[13] = '{32'h30004, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0};

    bus.mem_a = 32'h0;
    bus.mem_dout = 8'h00;
    bus.mem_wr = 1'b0;
    bus.io_tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].a, vecs[i].d, vecs[i].wr, vecs[i].txr, 1'b1);
      if (vecs[i].chkDin)
        checkVal($sformatf("vec%0d.din", i), {24'h0, bus.mem_din}, {24'h0, vecs[i].expDin});
      checkVal($sformatf("vec%0d.valid", i), {31'h0, bus.io_tx_valid}, {31'h0, vecs[i].expValid});
      checkVal($sformatf("vec%0d.data", i), {24'h0, bus.io_tx_data}, {24'h0, vecs[i].expData});
      checkVal($sformatf("vec%0d.full", i), {31'h0, bus.io_buffer_full}, {31'h0, vecs[i].expFull});
    end

    // FIFO fill with the drain stalled, then overflow and status readback.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h30000, 8'hC0 + 8'(i), 1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("fill%0d", i + 1));
      if (i == 4) checkVal("fill5.fullLow", {31'h0, bus.io_buffer_full}, 32'h0);
      if (i == 5) checkVal("fill6.fullHigh", {31'h0, bus.io_buffer_full}, 32'h1);
    end
    applyStimulus(32'h30000, 8'hEE, 1'b1, 1'b0, 1'b1);
    checkVal("push9.ovf", {31'h0, bus.tx_overflow}, 32'h1);
    checkVal("push9.head", {24'h0, bus.io_tx_data}, 32'hC0);
    applyStimulus(32'h30004, 8'h00, 1'b0, 1'b0, 1'b1);
    checkVal("status.din", {24'h0, bus.mem_din}, 32'h03);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h0, 8'h00, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("drain%0d", i + 1));
    end
    applyStimulus(32'h30000, 8'h5A, 1'b1, 1'b1, 1'b1);
    checkOutput("simul");
    checkVal("simul.head", {24'h0, bus.io_tx_data}, 32'hC6);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h00100, 8'h55, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("frozen%0d", i + 1));
      checkVal($sformatf("frozen%0d.head", i + 1), {24'h0, bus.io_tx_data}, 32'hC6);
    end
    applyStimulus(32'h00100, 8'h00, 1'b0, 1'b1, 1'b1);
    checkOutput("afterFreeze");
    checkVal("afterFreeze.din", {24'h0, bus.mem_din}, 32'h11);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h00101, 8'h00, 1'b0, 1'b1, 1'b1);
      checkOutput($sformatf("tail%0d", i + 1));
    end

    applyStimulus(32'h30004, 8'h7F, 1'b1, 1'b0, 1'b1);
    checkVal("progDone", {31'h0, bus.prog_done}, 32'h1);

    // Asynchronous reset between edges, with a RAM write presented while it is held.
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("asyncReset");
    fifoQ.delete();
    mOvf = 1'b0;
    mProg = 1'b0;
    mDin = 8'h00;
    mDinKnown = 1'b1;
    bus.mem_a = 32'h00200;
    bus.mem_dout = 8'hCC;
    bus.mem_wr = 1'b1;
    rdy = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("heldReset");
    rst_n = 1'b1;
    applyStimulus(32'h00200, 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("postReset");
    checkVal("postReset.ramKept", {24'h0, bus.mem_din}, 32'hBB);

    for (int n = 0; n < 400; n++) begin
      int sel = $urandom_range(0, 9);
      logic [31:0] a;
      if (sel <= 5) a = 32'h00400 + 32'($urandom_range(0, 15));
      else if (sel <= 7) a = 32'h30000;
      else if (sel == 8) a = 32'h30004;
      else a = 32'h30008;
      applyStimulus(a, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0);
      checkOutput($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
